vscale_htif_tohost_monitor: RTL and testbench
=============================================

Name: vscale_htif_tohost_monitor

Overview:
Synthesizable HTIF host-side poller that sits directly upstream of vscale_sim_top's HTIF PCR port. It replaces the constant-read tie-offs with a real request/response sequencer. It polls the tohost CSR and acknowledges (clears) a nonzero value. It decodes pass, fail or timeout into sticky status outputs that the simulation wrapper uses for $finish/reporting.

Parameters:
PCR_WIDTH, 64, HTIF PCR data width (matches `HTIF_PCR_WIDTH)
ADDR_WIDTH, 12, CSR address width
TOHOST_ADDR, 12'h780, CSR address polled (`CSR_ADDR_TO_HOST)
POLL_GAP, 4, idle cycles between consecutive zero-valued polls (>=1)
CNT_WIDTH, 64, width of cycle counter and max_cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  start monitoring; sampled only in IDLE, then ignored
max_cycles  in  CNT_WIDTH  timeout limit; 0 disables timeout
htif_pcr_req_valid  out  1  request valid
htif_pcr_req_ready  in  1  DUT accepts request
htif_pcr_req_rw  out  1  0=read, 1=write
htif_pcr_req_addr  out  ADDR_WIDTH  always TOHOST_ADDR
htif_pcr_req_data  out  PCR_WIDTH  write data (always 0)
htif_pcr_resp_valid  in  1  response valid
htif_pcr_resp_ready  out  1  monitor accepts response
htif_pcr_resp_data  in  PCR_WIDTH  response data
done  out  1  sticky: terminal state reached
pass  out  1  sticky: tohost==1 observed
fail  out  1  sticky: tohost nonzero and !=1
timeout  out  1  sticky: max_cycles exhausted
fail_code  out  PCR_WIDTH-1  tohost>>1 captured on fail
cycle_count  out  CNT_WIDTH  active cycles since enable

Behaviour:
- Reset (reset==0 at posedge): state=IDLE. All outputs 0, except req_addr=TOHOST_ADDR. Reset mid-transaction abandons it. No handshake obligation survives reset.
- FSM states: IDLE, REQ_RD, RESP_RD, GAP, REQ_CLR, RESP_CLR, DONE.
- IDLE: enable==1 -> REQ_RD next cycle. cycle_count stays 0.
- REQ_RD: req_valid=1, rw=0, data=0. Stay until req_valid&&req_ready, then go to RESP_RD. req_valid, rw, addr and data are stable while waiting.
- RESP_RD: resp_ready=1. On resp_valid, capture resp_data into tohost_q. If it is 0 -> GAP. Otherwise -> REQ_CLR.
- GAP: counts POLL_GAP cycles, then -> REQ_RD. req_valid=0.
- REQ_CLR: req_valid=1, rw=1, data=0. On handshake -> RESP_CLR.
- RESP_CLR: resp_ready=1. On resp_valid (data ignored) -> DONE.
  - pass = (tohost_q==1).
  - fail = !pass.
  - fail_code = tohost_q[PCR_WIDTH-1:1].
- DONE: terminal until reset. req_valid=0, resp_ready=0. done, pass, fail, timeout and fail_code are held.
- cycle_count increments by 1 every cycle in any state other than IDLE/DONE. It saturates at all-ones and never wraps.
- Timeout: in an active state with max_cycles!=0 and cycle_count==max_cycles-1, the next state is DONE with timeout=1. The first timeout cycle has cycle_count==max_cycles.
  - Any outstanding request/response is abandoned.
  - req_valid drops, which is permitted only on termination.
- Simultaneous events: if resp_valid with nonzero data arrives in RESP_RD on the timeout cycle, timeout wins. pass/fail stay 0 and fail_code stays 0.
- A clear-write response arriving on the timeout cycle: timeout wins.
- Exactly one of pass/fail/timeout is 1 whenever done==1. All are 0 while done==0.
- Only one request is outstanding at a time. No new request is issued before the prior response is consumed.

Decomposition:
- Shared package/header (vscale_htif_constants.vh): PCR_WIDTH, CSR address localparams (TOHOST, FROMHOST), FSM state encoding, rw encodings.
- Optional sub-module vscale_sat_counter (width param, en, clr, count) for cycle_count and the GAP counter. Otherwise the design is a single flat module.

Test Plan:
- Pass path: enable=1, max_cycles=0; DUT model returns tohost 0 three times, then 1 -> exactly 4 reads, one write with addr=0x780/data=0, then done=1, pass=1, fail_code=0.
- Fail code: tohost returns 0x2B -> clear write issued; done=1, fail=1, fail_code=21, pass=0, timeout=0.
- Timeout: max_cycles=50, tohost always 0 -> done=1 and timeout=1 first visible with cycle_count==50; req_valid==0 afterwards.
- Backpressure: req_ready held low 10 cycles, resp_valid delayed 7 cycles -> req fields stable throughout; no duplicate request; completes with pass after tohost=1.
- Simultaneous: max_cycles set so that timeout coincides with resp_valid carrying 1 -> timeout=1, pass=0.
- Reset mid-op: reset=0 during REQ_CLR -> all outputs 0 next cycle; after reset release with enable=1, polling restarts from REQ_RD with cycle_count from 0.

Source files
------------

// File: rtl/vscale_htif_tohost_monitor_pkg.sv
// Shared constants and FSM encoding for the HTIF tohost monitor.
package vscale_htif_tohost_monitor_pkg;

  localparam int HTIF_PCR_WIDTH = 64;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_RD   = 3'd1,
    ST_RESP_RD  = 3'd2,
    ST_GAP      = 3'd3,
    ST_REQ_CLR  = 3'd4,
    ST_RESP_CLR = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Active states are the ones that consume cycle budget.
  function automatic logic is_active(state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/vscale_htif_tohost_monitor_if.sv
// HTIF PCR request/response bus between the host-side monitor and the core.
interface vscale_htif_tohost_monitor_if #(
  parameter int PCR_WIDTH  = 64,
  parameter int ADDR_WIDTH = 12
);
  logic                  htif_pcr_req_valid;
  logic                  htif_pcr_req_ready;
  logic                  htif_pcr_req_rw;
  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr;
  logic [PCR_WIDTH-1:0]  htif_pcr_req_data;
  logic                  htif_pcr_resp_valid;
  logic                  htif_pcr_resp_ready;
  logic [PCR_WIDTH-1:0]  htif_pcr_resp_data;

  // Host side: issues requests, consumes responses.
  modport master (
    output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    output htif_pcr_resp_ready,
    input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
  );

  // Core side: accepts requests, produces responses.
  modport slave (
    input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    input  htif_pcr_resp_ready,
    output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
  );
endinterface

// File: rtl/vscale_htif_tohost_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module vscale_htif_tohost_monitor_sat_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, clear on reset or explicit clear, hold at max.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vscale_htif_tohost_monitor.sv
// Host-side HTIF poller: reads tohost until nonzero, clears it, and latches
// pass / fail / timeout as sticky status for the simulation wrapper.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for enable; cycle_count held at 0
//   REQ_RD   | read request to tohost presented, waiting for ready
//   RESP_RD  | waiting for read data; zero -> GAP, nonzero -> REQ_CLR
//   GAP      | POLL_GAP idle cycles between zero-valued polls
//   REQ_CLR  | write-0 request to tohost presented, waiting for ready
//   RESP_CLR | waiting for the clear-write response, then decode result
//   DONE     | terminal until reset; status outputs held
module vscale_htif_tohost_monitor
  import vscale_htif_tohost_monitor_pkg::*;
#(
  parameter int                    PCR_WIDTH   = HTIF_PCR_WIDTH,
  parameter int                    ADDR_WIDTH  = CSR_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = CSR_ADDR_TO_HOST,
  parameter int                    POLL_GAP    = 4,
  parameter int                    CNT_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] max_cycles,
  vscale_htif_tohost_monitor_if.master htif,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [PCR_WIDTH-2:0] fail_code,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_t               state;
  logic                 req_valid;
  logic                 req_rw;
  logic                 resp_ready;
  logic [PCR_WIDTH-1:0] tohost_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 active;
  logic                 tmo_hit;

  assign htif.htif_pcr_req_valid  = req_valid;
  assign htif.htif_pcr_req_rw     = req_rw;
  assign htif.htif_pcr_req_addr   = TOHOST_ADDR;
  assign htif.htif_pcr_req_data   = '0;
  assign htif.htif_pcr_resp_ready = resp_ready;

  assign active  = is_active(state);
  // Fires on the last budgeted cycle so the first DONE cycle shows count==max.
  assign tmo_hit = active && (max_cycles != '0) &&
                   (cycle_count == (max_cycles - CNT_WIDTH'(1)));

  vscale_htif_tohost_monitor_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_IDLE),
    .en    (active),
    .count (cycle_count)
  );

  // Sequencer with registered bus and status outputs; timeout pre-empts
  // every in-flight handshake, including a response on the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_valid  <= 1'b0;
      req_rw     <= RW_READ;
      resp_ready <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= '0;
      tohost_q   <= '0;
      gap_cnt    <= '0;
    end else if (tmo_hit) begin
      state      <= ST_DONE;
      req_valid  <= 1'b0;
      req_rw     <= RW_READ;
      resp_ready <= 1'b0;
      done       <= 1'b1;
      timeout    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_REQ_RD;
            req_valid <= 1'b1;
            req_rw    <= RW_READ;
          end
        end
        ST_REQ_RD: begin
          if (htif.htif_pcr_req_ready) begin
            state      <= ST_RESP_RD;
            req_valid  <= 1'b0;
            resp_ready <= 1'b1;
          end
        end
        ST_RESP_RD: begin
          if (htif.htif_pcr_resp_valid) begin
            tohost_q   <= htif.htif_pcr_resp_data;
            resp_ready <= 1'b0;
            if (htif.htif_pcr_resp_data == '0) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_W'(POLL_GAP - 1);
            end else begin
              state     <= ST_REQ_CLR;
              req_valid <= 1'b1;
              req_rw    <= RW_WRITE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state     <= ST_REQ_RD;
            req_valid <= 1'b1;
            req_rw    <= RW_READ;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ST_REQ_CLR: begin
          if (htif.htif_pcr_req_ready) begin
            state      <= ST_RESP_CLR;
            req_valid  <= 1'b0;
            req_rw     <= RW_READ;
            resp_ready <= 1'b1;
          end
        end
        ST_RESP_CLR: begin
          if (htif.htif_pcr_resp_valid) begin
            state      <= ST_DONE;
            resp_ready <= 1'b0;
            done       <= 1'b1;
            pass       <= (tohost_q == PCR_WIDTH'(1));
            fail       <= (tohost_q != PCR_WIDTH'(1));
            fail_code  <= tohost_q[PCR_WIDTH-1:1];
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state      <= ST_IDLE;
          req_valid  <= 1'b0;
          resp_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// Scoreboard bench for the HTIF tohost monitor: a bus responder plays the
// core side, stimulus queues expected requests/status, a monitor checks them.
module tb_vscale_htif_tohost_monitor;

  typedef struct {
    logic        rw;
    logic [11:0] addr;
    logic [63:0] data;
  } req_t;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [62:0] fcode;
    logic [63:0] cnt;
  } st_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [63:0] max_cycles;
  logic        done, pass, fail, timeout;
  logic [62:0] fail_code;
  logic [63:0] cycle_count;

  vscale_htif_tohost_monitor_if #(.PCR_WIDTH(64), .ADDR_WIDTH(12)) bus ();

  vscale_htif_tohost_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .max_cycles  (max_cycles),
    .htif        (bus),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .fail_code   (fail_code),
    .cycle_count (cycle_count)
  );

  int total = 0;
  int bad   = 0;

  req_t        exp_req[$];
  st_t         exp_st[$];
  logic [63:0] tohost_vals[$];
  int          cfg_rdy_delay = 0;
  int          cfg_rsp_delay = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_rd();
    req_t r;
    r.rw = 1'b0; r.addr = 12'h780; r.data = 64'd0;
    exp_req.push_back(r);
  endfunction

  function automatic void push_wr();
    req_t r;
    r.rw = 1'b1; r.addr = 12'h780; r.data = 64'd0;
    exp_req.push_back(r);
  endfunction

  function automatic void push_st(input logic p, input logic f, input logic t,
                                  input logic [62:0] code, input logic [63:0] cnt);
    st_t s;
    s.pass = p; s.fail = f; s.timeout = t; s.fcode = code; s.cnt = cnt;
    exp_st.push_back(s);
  endfunction

  // Core-side responder, acting just after each falling edge.
  bit          l_rv, l_rr, l_rw, l_pv, l_pr, l_rst;
  bit          rsp_pend;
  int          rdy_wait, rsp_wait;
  logic [63:0] rsp_val;

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      bus.htif_pcr_req_ready  = 1'b0;
      bus.htif_pcr_resp_valid = 1'b0;
      bus.htif_pcr_resp_data  = 64'd0;
      rsp_pend = 1'b0;
      rdy_wait = cfg_rdy_delay;
    end else begin
      if (l_rst && l_pv && l_pr) bus.htif_pcr_resp_valid = 1'b0;
      if (l_rst && l_rv && l_rr) begin
        bus.htif_pcr_req_ready = 1'b0;
        rdy_wait = cfg_rdy_delay;
        rsp_pend = 1'b1;
        rsp_wait = cfg_rsp_delay;
        if (!l_rw) rsp_val = (tohost_vals.size() != 0) ? tohost_vals.pop_front() : 64'd0;
        else       rsp_val = 64'hDEAD_BEEF;
      end
      if (rsp_pend && !bus.htif_pcr_resp_valid) begin
        if (rsp_wait == 0) begin
          bus.htif_pcr_resp_valid = 1'b1;
          bus.htif_pcr_resp_data  = rsp_val;
          rsp_pend = 1'b0;
        end else begin
          rsp_wait--;
        end
      end
      if (bus.htif_pcr_req_valid && !bus.htif_pcr_req_ready) begin
        if (rdy_wait == 0) bus.htif_pcr_req_ready = 1'b1;
        else               rdy_wait--;
      end
    end
    l_rv  = bus.htif_pcr_req_valid;
    l_rr  = bus.htif_pcr_req_ready;
    l_rw  = bus.htif_pcr_req_rw;
    l_pv  = bus.htif_pcr_resp_valid;
    l_pr  = bus.htif_pcr_resp_ready;
    l_rst = reset;
  end

  // Monitor: pops expectations on request handshakes and on done rising.
  bit          done_seen;
  bit          held_ok;
  st_t         held;
  req_t        m_req;
  bit          p_rst, p_rv, p_rr, p_rw;
  logic [11:0] p_addr;
  logic [63:0] p_data;

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      done_seen = 1'b0;
      held_ok   = 1'b0;
    end else begin
      if (bus.htif_pcr_req_valid && bus.htif_pcr_req_ready) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_req", {63'd0, bus.htif_pcr_req_rw}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          m_req = exp_req.pop_front();
          chk("req_rw",   {63'd0, bus.htif_pcr_req_rw}, {63'd0, m_req.rw});
          chk("req_addr", {52'd0, bus.htif_pcr_req_addr}, {52'd0, m_req.addr});
          chk("req_data", bus.htif_pcr_req_data, m_req.data);
        end
      end
      if (p_rst && p_rv && !p_rr) begin
        chk("req_held", {63'd0, bus.htif_pcr_req_valid | done}, 64'd1);
        if (bus.htif_pcr_req_valid) begin
          chk("req_stable_rw",   {63'd0, bus.htif_pcr_req_rw}, {63'd0, p_rw});
          chk("req_stable_addr", {52'd0, bus.htif_pcr_req_addr}, {52'd0, p_addr});
          chk("req_stable_data", bus.htif_pcr_req_data, p_data);
        end
      end
      if (done) begin
        if (!done_seen) begin
          done_seen = 1'b1;
          if (exp_st.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            held    = exp_st.pop_front();
            held_ok = 1'b1;
          end
        end
        if (held_ok) begin
          chk("pass",        {63'd0, pass},    {63'd0, held.pass});
          chk("fail",        {63'd0, fail},    {63'd0, held.fail});
          chk("timeout",     {63'd0, timeout}, {63'd0, held.timeout});
          chk("fail_code",   {1'b0, fail_code}, {1'b0, held.fcode});
          chk("cycle_count", cycle_count, held.cnt);
        end
        chk("done_req_valid",  {63'd0, bus.htif_pcr_req_valid},  64'd0);
        chk("done_resp_ready", {63'd0, bus.htif_pcr_resp_ready}, 64'd0);
      end else begin
        chk("status_quiet", {61'd0, pass, fail, timeout}, 64'd0);
      end
    end
    p_rst  = reset;
    p_rv   = bus.htif_pcr_req_valid;
    p_rr   = bus.htif_pcr_req_ready;
    p_rw   = bus.htif_pcr_req_rw;
    p_addr = bus.htif_pcr_req_addr;
    p_data = bus.htif_pcr_req_data;
  end

  task automatic check_reset_state();
    chk("rst_req_valid",  {63'd0, bus.htif_pcr_req_valid},  64'd0);
    chk("rst_req_rw",     {63'd0, bus.htif_pcr_req_rw},     64'd0);
    chk("rst_req_addr",   {52'd0, bus.htif_pcr_req_addr},   64'h780);
    chk("rst_req_data",   bus.htif_pcr_req_data,            64'd0);
    chk("rst_resp_ready", {63'd0, bus.htif_pcr_resp_ready}, 64'd0);
    chk("rst_status",     {60'd0, done, pass, fail, timeout}, 64'd0);
    chk("rst_fail_code",  {1'b0, fail_code}, 64'd0);
    chk("rst_cycle_count", cycle_count, 64'd0);
  endtask

  // Hold reset, program the responder, and check the reset state.
  task automatic start_test(input logic [63:0] maxc, input int rdy, input int rsp);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    max_cycles = maxc;
    cfg_rdy_delay = rdy;
    cfg_rsp_delay = rsp;
    tohost_vals.delete();
    exp_req.delete();
    exp_st.delete();
    @(negedge clk);
    #2;
    check_reset_state();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic finish_test(input string name, input int budget);
    int i;
    i = 0;
    while (i < budget && !done_seen) begin
      @(negedge clk);
      #3;
      i++;
    end
    if (!done_seen) $display("FAIL %s: done not reached within %0d cycles", name, budget);
    chk("done_reached", {63'd0, done_seen}, 64'd1);
    repeat (3) @(negedge clk);
    #3;
    chk("req_all_seen", 64'(exp_req.size()), 64'd0);
    chk("st_all_seen",  64'(exp_st.size()),  64'd0);
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    enable = 1'b0;
    max_cycles = 64'd0;
    bus.htif_pcr_req_ready  = 1'b0;
    bus.htif_pcr_resp_valid = 1'b0;
    bus.htif_pcr_resp_data  = 64'd0;

    // Pass after three zero polls: 3*(1+1+4) + 4 = 22 active cycles.
    start_test(64'd0, 0, 0);
    tohost_vals = '{64'd0, 64'd0, 64'd0, 64'd1};
    repeat (4) push_rd();
    push_wr();
    push_st(1'b1, 1'b0, 1'b0, 63'd0, 64'd22);
    release_reset();
    finish_test("pass_path", 200);

    // Fail with code 0x2B >> 1 = 21.
    start_test(64'd0, 0, 0);
    tohost_vals = '{64'h2B};
    push_rd(); push_wr();
    push_st(1'b0, 1'b1, 1'b0, 63'd21, 64'd4);
    release_reset();
    finish_test("fail_code", 100);

    // Timeout at 50: reads at counts 0,6,...,48, timeout in RESP_RD.
    start_test(64'd50, 0, 0);
    repeat (9) push_rd();
    push_st(1'b0, 1'b0, 1'b1, 63'd0, 64'd50);
    release_reset();
    finish_test("timeout", 200);

    // Backpressure: each request waits 11 cycles, each response 8.
    start_test(64'd0, 10, 7);
    tohost_vals = '{64'd1};
    push_rd(); push_wr();
    push_st(1'b1, 1'b0, 1'b0, 63'd0, 64'd38);
    release_reset();
    finish_test("backpressure", 300);

    // Read response carrying 1 lands on the timeout cycle.
    start_test(64'd2, 0, 0);
    tohost_vals = '{64'd1};
    push_rd();
    push_st(1'b0, 1'b0, 1'b1, 63'd0, 64'd2);
    release_reset();
    finish_test("simul_read", 100);

    // Clear-write response lands on the timeout cycle.
    start_test(64'd4, 0, 0);
    tohost_vals = '{64'd5};
    push_rd(); push_wr();
    push_st(1'b0, 1'b0, 1'b1, 63'd0, 64'd4);
    release_reset();
    finish_test("simul_clear", 100);

    // Reset while the clear write is stalled, then restart cleanly.
    start_test(64'd0, 10, 0);
    tohost_vals = '{64'd3};
    push_rd();
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #3;
      if (bus.htif_pcr_req_valid && bus.htif_pcr_req_rw) found = 1'b1;
    end
    chk("saw_req_clr", {63'd0, found}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    cfg_rdy_delay = 0;
    @(negedge clk);
    #2;
    check_reset_state();
    chk("midop_req_left", 64'(exp_req.size()), 64'd0);
    tohost_vals.delete();
    tohost_vals = '{64'd1};
    push_rd(); push_wr();
    push_st(1'b1, 1'b0, 1'b0, 63'd0, 64'd4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #3;
    chk("restart_req_valid", {63'd0, bus.htif_pcr_req_valid}, 64'd1);
    chk("restart_req_rw",    {63'd0, bus.htif_pcr_req_rw},    64'd0);
    chk("restart_count",     cycle_count, 64'd0);
    finish_test("reset_midop", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
